// File: rtl/ad9361_ctrl_out_monitor.sv
// AD9361 CTRL_OUT monitor: synchronizes and glitch-filters the status pins,
// then queues timestamped masked-edge events in a FWFT FIFO with overflow tracking.
module ad9361_ctrl_out_monitor #(
  parameter int WIDTH       = 8,
  parameter int FILT_CYCLES = 4,
  parameter int TS_WIDTH    = 24,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [WIDTH-1:0]            status_in,
  input  logic [WIDTH-1:0]            rise_mask,
  input  logic [WIDTH-1:0]            fall_mask,
  output logic [WIDTH-1:0]            status_filt,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [TS_WIDTH+2*WIDTH-1:0] evt_data,
  output logic                        evt_overflow,
  input  logic                        overflow_clr,
  output logic [7:0]                  drop_count,
  output logic                        irq
);

  localparam int DW = TS_WIDTH + 2 * WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] FILT_LAST = 8'(FILT_CYCLES - 1);

  logic [WIDTH-1:0]    sync_a;
  logic [WIDTH-1:0]    sync_s;
  logic [WIDTH-1:0]    filt_prev;
  logic [7:0]          cnt [WIDTH];
  logic [TS_WIDTH-1:0] ts;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic [WIDTH-1:0]    changed;
  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                fifo_full;
  logic                wr_req;
  logic                pop;
  logic                wr_en;
  logic                drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a <= '0;
      sync_s <= '0;
    end else begin
      sync_a <= status_in;
      sync_s <= sync_a;
    end
  end

  // A bit only flips once the synchronized level has disagreed for FILT_CYCLES samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_s[i] == status_filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FILT_LAST) begin
          status_filt[i] <= sync_s[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts        <= '0;
      filt_prev <= '0;
    end else begin
      ts        <= ts + TS_WIDTH'(1);
      filt_prev <= status_filt;
    end
  end

  assign rise      = status_filt & ~filt_prev & rise_mask;
  assign fall      = ~status_filt & filt_prev & fall_mask;
  assign changed   = rise | fall;
  assign wr_req    = |changed;
  assign evt_valid = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = evt_valid & evt_ready;
  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign wr_en     = wr_req & (~fifo_full | pop);
  assign drop      = wr_req & fifo_full & ~pop;
  assign irq       = evt_valid;
  assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // ts still holds the value from the cycle in which status_filt changed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ts, status_filt, changed};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // A drop on the same cycle as a clear leaves the drop recorded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evt_overflow <= 1'b0;
      drop_count   <= '0;
    end else if (drop) begin
      evt_overflow <= 1'b1;
      if (overflow_clr)               drop_count <= 8'd1;
      else if (drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
    end else if (overflow_clr) begin
      evt_overflow <= 1'b0;
      drop_count   <= '0;
    end
  end

endmodule
